// File: rtl/sysbus_mem_responder_pkg.sv
// sysbus_mem_responder_pkg: shared SysBus width constant and bus-target state encoding.
package sysbus_mem_responder_pkg;
  localparam int SYSBUS_W = 16;
  typedef enum logic [1:0] {BusIdle, BusAddr, BusRead, BusWrite} bus_state_t;
endpackage

// File: rtl/sysbus_ram_array.sv
// sysbus_ram_array: word array with synchronous write and synchronous read, no reset.
//   Clock  : write and read-register clock
//   WrEn   : commit WrData to WrIdx on the rising edge
//   WrIdx  : write word index
//   WrData : write word
//   RdIdx  : read word index, sampled every rising edge
//   RdData : registered read word
module sysbus_ram_array #(
  parameter int DW = 16,
  parameter int AW = 10
) (
  input  logic          Clock,
  input  logic          WrEn,
  input  logic [AW-1:0] WrIdx,
  input  logic [DW-1:0] WrData,
  input  logic [AW-1:0] RdIdx,
  output logic [DW-1:0] RdData
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge Clock) begin
    if (WrEn) mem[WrIdx] <= WrData;
    RdData <= mem[RdIdx];
  end
endmodule

// File: rtl/sysbus_mem_responder.sv
// sysbus_mem_responder: SysBus memory target decoding ALE/nME/nOE/nWE into array reads and writes.
//   Clock     : system clock
//   nReset    : asynchronous active-low reset
//   SysBusIn  : pad value (address during ALE, write data during a write)
//   SysBusOut : read data toward the pad driver
//   SysBusOe  : this block drives SysBus
//   ALE       : address latch enable, active high
//   nME       : memory enable, active low
//   nOE       : read strobe, active low
//   nWE       : write strobe, active low
//   Selected  : latched address lies inside [BASE, BASE+DEPTH)
//   BusErr    : one-cycle pulse after a cycle with nOE and nWE both low
module sysbus_mem_responder
  import sysbus_mem_responder_pkg::*;
#(
  parameter int            DW    = SYSBUS_W,
  parameter logic [DW-1:0] BASE  = '0,
  parameter int            DEPTH = 1024
) (
  input  logic          Clock,
  input  logic          nReset,
  input  logic [DW-1:0] SysBusIn,
  output logic [DW-1:0] SysBusOut,
  output logic          SysBusOe,
  input  logic          ALE,
  input  logic          nME,
  input  logic          nOE,
  input  logic          nWE,
  output logic          Selected,
  output logic          BusErr
);
  localparam int AW = $clog2(DEPTH);
  // One extra bit so a window ending at 2^DW does not wrap.
  localparam logic [DW:0] LO = {1'b0, BASE};
  localparam logic [DW:0] HI = LO + (DW+1)'(DEPTH);
  bus_state_t    state_q, state_d;
  logic [DW-1:0] addr_q, addr_d, wrbuf_q, wrbuf_d, ram_rd;
  logic          sel_q, sel_d, err_q, err, wr_en, in_win;
  logic [AW-1:0] idx;
  assign in_win = ({1'b0, SysBusIn} >= LO) && ({1'b0, SysBusIn} < HI);
  assign idx = AW'(addr_q - BASE);
  assign err = (state_q != BusIdle) && !ALE && !nME && !nOE && !nWE;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    wrbuf_d = wrbuf_q;
    wr_en   = 1'b0;
    if (ALE) begin
      state_d = BusAddr;
      addr_d  = SysBusIn;
      sel_d   = in_win;
    end else if (err) begin
      state_d = BusAddr;
    end else begin
      case (state_q)
        BusAddr:
          if (!nME && !nOE && nWE) state_d = BusRead;
          else if (!nME && !nWE && nOE) begin
            state_d = BusWrite;
            wrbuf_d = SysBusIn;
          end
        BusRead:  state_d = nME ? BusIdle : (nOE ? BusAddr : BusRead);
        BusWrite:
          if (!nWE) wrbuf_d = SysBusIn;
          else begin
            wr_en   = sel_q;
            state_d = nME ? BusIdle : BusAddr;
          end
        default: ;
      endcase
    end
  end
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= BusIdle;
      addr_q  <= '0;
      wrbuf_q <= '0;
      sel_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wrbuf_q <= wrbuf_d;
      sel_q   <= sel_d;
      err_q   <= err;
    end
  end
  sysbus_ram_array #(.DW(DW), .AW(AW)) u_ram (
    .Clock (Clock),
    .WrEn  (wr_en),
    .WrIdx (idx),
    .WrData(wrbuf_q),
    .RdIdx (idx),
    .RdData(ram_rd)
  );
  // Drive follows the live strobes so it drops in the cycle nOE/nME rises or nWE collides.
  assign SysBusOe  = (state_q == BusRead) && sel_q && !nOE && !nME && nWE;
  assign SysBusOut = (state_q == BusRead) ? ram_rd : '0;
  assign Selected  = sel_q;
  assign BusErr    = err_q;
endmodule
